// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the fetch-stage controller.
// Imported by if_fetch_ctrl and if_hold_buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buffer.sv
// Single-entry parking slot for an instruction that returned while the pipeline was stalled.
// Loads in one cycle, clear has priority over load; no backpressure of its own.
module if_hold_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  addr_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  addr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            addr  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            addr  <= addr_in;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns PC, the imem req/ack handshake and the IF/ID register.
// IF/ID updates one cycle after ack; stalls park returned data, redirects drop wrong-path data.
// Optional FETCH_STATS_EN adds saturating stall/flush/bubble counters.
module if_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_INSTR)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               IF_ID_flush,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] IF_ID_Instruction,
    output logic [ADDR_W-1:0]  IF_ID_PCPlus4,
    output logic               IF_ID_Valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count,
    output logic [31:0]        bubble_cycles
`endif
);

    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

    fetch_state_t       state, state_n;
    logic [ADDR_W-1:0]  req_addr, req_addr_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [INSTR_W-1:0] id_instr_n;
    logic [ADDR_W-1:0]  id_pc4_n;
    logic               id_valid_n;

    logic               stall;
    logic               flush_evt;
    logic               ack;
    logic               bubble;
    logic               buf_load;
    logic               buf_clear;
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_addr;

    // Request is suppressed in the reset cycle so memory never sees a stale address.
    assign imem_req  = Rst && (state != HOLD);
    assign imem_addr = req_addr;
    assign ack       = imem_ack && imem_req;
    assign stall     = !PCWrite || !IF_ID_Write;
    assign flush_evt = redirect || IF_ID_flush;

    if_hold_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_hold_buffer (
        .clk      (Clk),
        .rst_n    (Rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rdata),
        .addr_in  (req_addr),
        .valid    (buf_valid),
        .instr    (buf_instr),
        .addr     (buf_addr)
    );

    always_comb begin
        state_n    = state;
        pc_n       = PC;
        req_addr_n = req_addr;
        id_instr_n = IF_ID_Instruction;
        id_pc4_n   = IF_ID_PCPlus4;
        id_valid_n = IF_ID_Valid;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        bubble     = 1'b0;

        if (flush_evt) begin
            id_instr_n = NOP_WORD;
            id_pc4_n   = '0;
            id_valid_n = 1'b0;
            buf_clear  = 1'b1;
            pc_n       = redirect ? redirect_pc : PC;
            // An unanswered request must still be drained before the new address goes out.
            if (state != HOLD && !ack) begin
                state_n = DROP;
            end else begin
                req_addr_n = pc_n;
                state_n    = FETCH;
            end
        end else if (state == DROP) begin
            bubble = !stall;
            if (ack) begin
                req_addr_n = PC;
                state_n    = FETCH;
            end
        end else if (stall) begin
            if (state == FETCH && ack) begin
                buf_load = 1'b1;
                state_n  = HOLD;
            end
        end else if (buf_valid) begin
            id_instr_n = buf_instr;
            id_pc4_n   = buf_addr + INCR;
            id_valid_n = 1'b1;
            pc_n       = buf_addr + INCR;
            req_addr_n = buf_addr + INCR;
            buf_clear  = 1'b1;
            state_n    = FETCH;
        end else if (ack) begin
            id_instr_n = imem_rdata;
            id_pc4_n   = req_addr + INCR;
            id_valid_n = 1'b1;
            pc_n       = req_addr + INCR;
            req_addr_n = req_addr + INCR;
        end else begin
            bubble = 1'b1;
        end

        if (bubble) begin
            id_instr_n = NOP_WORD;
            id_pc4_n   = '0;
            id_valid_n = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state             <= FETCH;
            PC                <= RESET_PC;
            req_addr          <= RESET_PC;
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else begin
            state             <= state_n;
            PC                <= pc_n;
            req_addr          <= req_addr_n;
            IF_ID_Instruction <= id_instr_n;
            IF_ID_PCPlus4     <= id_pc4_n;
            IF_ID_Valid       <= id_valid_n;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            bubble_cycles <= '0;
        end else begin
            if (stall && !flush_evt && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_evt && flush_count != '1) begin
                flush_count <= flush_count + 16'd1;
            end
            if (bubble && bubble_cycles != '1) begin
                bubble_cycles <= bubble_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pcw, idw, flush, redir, ack;
    logic [31:0] rpc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata, pc, id_instr, id_pc4;
    logic        id_vld;

    // Memory returns the address itself as the instruction word.
    assign imem_rdata = imem_addr;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl dut (
        .Clk               (clk),
        .Rst               (rst),
        .PCWrite           (pcw),
        .IF_ID_Write       (idw),
        .IF_ID_flush       (flush),
        .redirect          (redir),
        .redirect_pc       (rpc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (ack),
        .imem_rdata        (imem_rdata),
        .PC                (pc),
        .IF_ID_Instruction (id_instr),
        .IF_ID_PCPlus4     (id_pc4),
        .IF_ID_Valid       (id_vld)
    );

    // Reference model: where fetching is aimed, whether a parked word exists,
    // and whether the outstanding response belongs to an abandoned path.
    logic [31:0] m_pc, m_fetch, m_instr, m_pc4, m_held_word, m_held_addr;
    bit          m_vld, m_held, m_wrong;

    function automatic bit m_req();
        return rst && !m_held;
    endfunction

    task automatic model_step();
        bit accepted, was_held;
        if (!rst) begin
            m_pc = 32'h0; m_fetch = 32'h0; m_wrong = 0; m_held = 0;
            m_instr = NOP; m_pc4 = 32'h0; m_vld = 0;
            return;
        end
        was_held = m_held;
        accepted = ack && !m_held;
        if (redir || flush) begin
            m_instr = NOP; m_pc4 = 0; m_vld = 0;
            if (redir) m_pc = rpc;
            m_held = 0;
            if (!was_held && !accepted) m_wrong = 1;
            else begin m_fetch = m_pc; m_wrong = 0; end
        end else if (m_wrong) begin
            if (pcw && idw) begin m_instr = NOP; m_pc4 = 0; m_vld = 0; end
            if (accepted) begin m_wrong = 0; m_fetch = m_pc; end
        end else if (!pcw || !idw) begin
            if (accepted) begin m_held = 1; m_held_word = m_fetch; m_held_addr = m_fetch; end
        end else if (m_held) begin
            m_instr = m_held_word; m_pc4 = m_held_addr + 4; m_vld = 1;
            m_pc = m_held_addr + 4; m_fetch = m_pc; m_held = 0;
        end else if (accepted) begin
            m_instr = m_fetch; m_pc4 = m_fetch + 4; m_vld = 1;
            m_pc = m_fetch + 4; m_fetch = m_pc;
        end else begin
            m_instr = NOP; m_pc4 = 0; m_vld = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 0; pcw = 1; idw = 1; flush = 0; redir = 0; ack = 0; rpc = 0;
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; pcw = 1; idw = 1; flush = 0; redir = 0; ack = 1; rpc = 32'h40;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
        checks++; if (id_vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_vld); end
        checks++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", id_instr, NOP); end
        checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", id_pc4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        rst = 1;
    endtask

    task automatic test_zero_wait();
        do_reset();
        ack = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
                errors++; $display("FAIL zw_req%0d got %b/%h exp 1/%h", i, imem_req, imem_addr, 32'(i * 4)); end
            tick();
            checks++; if (id_vld !== 1'b1 || id_instr !== 32'(i * 4) || id_pc4 !== 32'(i * 4 + 4)) begin
                errors++; $display("FAIL zw_ifid%0d got %b/%h/%h exp 1/%h/%h", i, id_vld, id_instr, id_pc4, 32'(i * 4), 32'(i * 4 + 4)); end
        end
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL zw_pc got %h exp c", pc); end
    endtask

    task automatic test_ack_delay();
        do_reset();
        ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                errors++; $display("FAIL delay_req%0d got %b/%h exp 1/0", i, imem_req, imem_addr); end
            tick();
            checks++; if (id_vld !== 1'b0 || id_instr !== NOP || pc !== 32'h0) begin
                errors++; $display("FAIL delay_bubble%0d got %b/%h pc %h exp 0/%h pc 0", i, id_vld, id_instr, pc, NOP); end
        end
        ack = 1;
        tick();
        checks++; if (id_vld !== 1'b1 || id_instr !== 32'h0 || pc !== 32'h4) begin
            errors++; $display("FAIL delay_ack got %b/%h pc %h exp 1/0 pc 4", id_vld, id_instr, pc); end
    endtask

    task automatic test_stall();
        pcw = 0; idw = 0; ack = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ack = 0;
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d got %b exp 0", i, imem_req); end
            tick();
            checks++; if (id_vld !== 1'b1 || id_instr !== 32'h0 || pc !== 32'h4) begin
                errors++; $display("FAIL hold_ifid%0d got %b/%h pc %h exp 1/0 pc 4", i, id_vld, id_instr, pc); end
        end
        pcw = 1; idw = 1; ack = 0;
        tick();
        checks++; if (id_vld !== 1'b1 || id_instr !== 32'h4 || id_pc4 !== 32'h8 || pc !== 32'h8) begin
            errors++; $display("FAIL hold_release got %b/%h/%h pc %h exp 1/4/8 pc 8", id_vld, id_instr, id_pc4, pc); end
    endtask

    task automatic test_redirect();
        ack = 0; redir = 1; rpc = 32'h100;
        tick();
        redir = 0;
        checks++; if (id_vld !== 1'b0 || pc !== 32'h100) begin
            errors++; $display("FAIL redir_ifid got %b pc %h exp 0 pc 100", id_vld, pc); end
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL redir_drop_req got %b/%h exp 1/8", imem_req, imem_addr); end
        tick();
        ack = 1;
        tick();
        checks++; if (id_vld !== 1'b0 || id_instr !== NOP) begin
            errors++; $display("FAIL redir_discard got %b/%h exp 0/%h", id_vld, id_instr, NOP); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_newreq got %h exp 100", imem_addr); end
        tick();
        checks++; if (id_vld !== 1'b1 || id_instr !== 32'h100 || pc !== 32'h104) begin
            errors++; $display("FAIL redir_target got %b/%h pc %h exp 1/100 pc 104", id_vld, id_instr, pc); end
    endtask

    task automatic test_redirect_stall();
        pcw = 0; redir = 1; rpc = 32'h200; ack = 0;
        tick();
        pcw = 1; redir = 0;
        checks++; if (pc !== 32'h200 || id_vld !== 1'b0) begin
            errors++; $display("FAIL rs_pc got %h/%b exp 200/0", pc, id_vld); end
        ack = 1;
        tick();
        tick();
        checks++; if (id_vld !== 1'b1 || id_instr !== 32'h200) begin
            errors++; $display("FAIL rs_target got %b/%h exp 1/200", id_vld, id_instr); end
    endtask

    task automatic test_flush_only();
        logic [31:0] exp_pc;
        exp_pc = m_pc;
        flush = 1; ack = 1;
        tick();
        flush = 0;
        checks++; if (id_vld !== 1'b0 || pc !== exp_pc) begin
            errors++; $display("FAIL flush_only got %b pc %h exp 0 pc %h", id_vld, pc, exp_pc); end
    endtask

    task automatic test_wrap();
        redir = 1; rpc = 32'hFFFF_FFFC; ack = 1;
        tick();
        redir = 0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %h exp fffffffc", imem_addr); end
        tick();
        checks++; if (id_instr !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || pc !== 32'h0) begin
            errors++; $display("FAIL wrap got %h/%h pc %h exp fffffffc/0 pc 0", id_instr, id_pc4, pc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) != 0);
            ack   = ($urandom_range(0, 99) < 55);
            pcw   = ($urandom_range(0, 99) >= 15);
            idw   = ($urandom_range(0, 99) >= 10);
            redir = ($urandom_range(0, 99) < 8);
            flush = ($urandom_range(0, 99) < 4);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            #1;
            checks++; if (imem_req !== m_req() || (m_req() && imem_addr !== m_fetch)) begin
                errors++; $display("FAIL rnd_req%0d got %b/%h exp %b/%h", i, imem_req, imem_addr, m_req(), m_fetch); end
            tick();
            checks++; if (pc !== m_pc || id_vld !== m_vld || id_instr !== m_instr || id_pc4 !== m_pc4) begin
                errors++; $display("FAIL rnd_state%0d got pc %h v %b i %h p4 %h exp pc %h v %b i %h p4 %h",
                                   i, pc, id_vld, id_instr, id_pc4, m_pc, m_vld, m_instr, m_pc4); end
        end
    endtask

    initial begin
        rst = 0; pcw = 1; idw = 1; flush = 0; redir = 0; ack = 0; rpc = 0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_flush_only();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage controller that consumes the pipeline's hazard outputs (PCWrite, IF_ID_Write, IF_ID_flush) together with the branch/jump redirect.
- Owns the PC, the instruction-memory request/acknowledge handshake and the IF/ID pipeline register.
- Holds the fetched instruction on stalls, discards wrong-path fetches on redirect, and inserts NOP bubbles while memory is busy.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width
NOP_WORD, 32'h0000_0000, instruction placed in IF/ID on bubble or flush

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  synchronous, active-low reset
PCWrite  in  1  hazard unit: 1 = PC may advance
IF_ID_Write  in  1  hazard unit: 1 = IF/ID may load
IF_ID_flush  in  1  hazard unit: squash IF/ID contents
redirect  in  1  taken branch/jump/jr this cycle
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  memory request valid
imem_addr  out  ADDR_W  request address
imem_ack  in  1  data valid for the outstanding request
imem_rdata  in  INSTR_W  returned instruction
PC  out  ADDR_W  current fetch PC
IF_ID_Instruction  out  INSTR_W  IF/ID instruction
IF_ID_PCPlus4  out  ADDR_W  IF/ID PC+4
IF_ID_Valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (Rst=0 at posedge):
  - PC=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0, hold buffer empty.
  - imem_req is 0 during the reset cycle.
  - Reset mid-request abandons the request; memory must tolerate this.
- States:
  - FETCH: imem_req=1, imem_addr=req_addr.
  - HOLD: imem_req=0; the fetched word waits in the hold buffer.
  - DROP: imem_req=1 with the old req_addr; the returned data is discarded.
- Handshake: once raised, imem_req and imem_addr stay stable until the cycle in which imem_ack=1. Ack is accepted only while imem_req=1. Ack at most one per request. Zero-wait memory (ack in the same cycle) is legal.
- Priority per posedge: reset > redirect/flush > stall > normal.
- Redirect (redirect=1, or IF_ID_flush=1):
  - IF/ID <= NOP_WORD with Valid=0.
  - If redirect=1: PC <= redirect_pc.
  - In FETCH with no ack this cycle: go to DROP. Otherwise: req_addr <= new PC, state=FETCH.
  - Hold buffer cleared.
  - IF_ID_flush alone, without redirect, squashes IF/ID only; PC is unchanged.
- DROP: on ack, discard the data, req_addr <= PC, go to FETCH. A further redirect while in DROP updates PC only.
- Stall (PCWrite=0 or IF_ID_Write=0, no redirect):
  - IF/ID and PC hold.
  - FETCH with ack: capture imem_rdata and req_addr into the hold buffer, go to HOLD.
- HOLD, stall released: IF/ID <= buffer (Valid=1, PCPlus4 = buffer addr + 4), PC <= buffer addr + 4, req_addr <= same, go to FETCH.
- Normal, FETCH with ack: IF/ID <= imem_rdata (Valid=1, PCPlus4 = req_addr + 4), PC <= req_addr + 4, next request issued the following cycle.
- Normal, FETCH without ack: IF/ID <= NOP_WORD with Valid=0 (bubble); PC holds.
- Arithmetic: +4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0 with no flag.
- Latency: zero-wait memory sustains one instruction per cycle; the first valid IF/ID appears 2 cycles after reset release.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds outputs stall_cycles[31:0], flush_count[15:0] and bubble_cycles[31:0], all cleared by reset and saturating at all-ones.
  - stall_cycles increments in each stall cycle; flush_count on each redirect/flush edge; bubble_cycles on each NOP insertion.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (fetch_pkg):
  - state enum {FETCH, HOLD, DROP}.
  - NOP constant, PC_INCR=4, default RESET_PC.
- Sub-module if_hold_buffer: single-entry instruction+address register with load/clear/valid, instantiated once.

Test Plan:
- Reset released, memory acks every cycle with rdata=addr: IF/ID shows instructions 0x0, 0x4, 0x8 on consecutive cycles; PC=0xC afterwards.
- Ack delayed 3 cycles: imem_addr stays stable; 3 NOP bubbles with Valid=0; PC stays 0 until the ack.
- IF_ID_Write=PCWrite=0 for 4 cycles with ack during the stall: IF/ID unchanged, imem_req=0 in HOLD; on release IF/ID loads the held word and PC=held+4.
- redirect=1, redirect_pc=0x100 while a request to 0x8 is outstanding: IF/ID Valid=0, DROP until ack; the 0x8 data never appears; next request is to 0x100.
- Redirect and stall in the same cycle: redirect wins; PC=redirect_pc.
- PC=0xFFFF_FFFC fetched with ack: PCPlus4=0, PC wraps to 0.
